// File: rtl/rw_ctrl.sv
// CPU read/write control for an 8253-style timer: control-word decode, LSB/MSB count
// load sequencing and count-latch read-back for up to three counter channels.
module rw_ctrl #(
    parameter int NCH    = 3,
    parameter bit BCD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [1:0]        addr,
    input  logic [7:0]        din,
    input  logic [16*NCH-1:0] cnt_in,
    output logic [7:0]        dout,
    output logic              dout_vld,
    output logic [16*NCH-1:0] cnt_val,
    output logic [NCH-1:0]    load,
    output logic [NCH-1:0]    cw_wr,
    output logic [3*NCH-1:0]  mode,
    output logic [NCH-1:0]    bcd,
    output logic [NCH-1:0]    armed
);

    typedef enum logic [1:0] {W_IDLE, W_LSB, W_MSB} wst_t;

    logic [1:0] w_sc;
    logic [1:0] w_rw;
    logic [2:0] w_mode_dec;
    logic       w_rd_ok;
    logic [7:0] w_rd_data;
    logic [7:0] w_rbyte [NCH];
    logic [7:0] r_dout;
    logic       r_dout_vld;

    assign w_sc       = din[7:6];
    assign w_rw       = din[5:4];
    // Modes 6 and 7 alias modes 2 and 3.
    assign w_mode_dec = (din[3:2] == 2'b11) ? {1'b0, din[2:1]} : din[3:1];
    assign w_rd_ok    = rd && !wr;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam logic [1:0] CH = 2'(gi);

        wst_t        r_wst, w_wst_nxt;
        logic [15:0] r_cnt, w_cnt_nxt, r_latch, w_src;
        logic [7:0]  r_lsb, w_lsb_nxt;
        logic [1:0]  r_rwfmt;
        logic [2:0]  r_mode;
        logic        r_armed, r_latched, r_rdtog, r_load, r_cw_wr, r_bcd;
        logic        w_load_nxt, w_cw_hit, w_cw_set, w_cw_latch;
        logic        w_wr_hit, w_rd_hit, w_rd_msb, w_rd_last;

        assign w_cw_hit   = wr && (addr == 2'd3) && (w_sc == CH);
        assign w_cw_set   = w_cw_hit && (w_rw != 2'b00);
        assign w_cw_latch = w_cw_hit && (w_rw == 2'b00) && r_armed && !r_latched;
        assign w_wr_hit   = wr && (addr == CH);
        assign w_rd_hit   = w_rd_ok && (addr == CH);

        always_comb begin
            w_wst_nxt  = r_wst;
            w_cnt_nxt  = r_cnt;
            w_lsb_nxt  = r_lsb;
            w_load_nxt = 1'b0;
            if (w_cw_set) begin
                w_wst_nxt = (w_rw == 2'b10) ? W_MSB : W_LSB;
            end else if (w_wr_hit) begin
                case (r_wst)
                    W_LSB: begin
                        if (r_rwfmt == 2'b01) begin
                            w_cnt_nxt  = {8'h00, din};
                            w_load_nxt = 1'b1;
                        end else begin
                            w_lsb_nxt = din;
                            w_wst_nxt = W_MSB;
                        end
                    end
                    W_MSB: begin
                        w_load_nxt = 1'b1;
                        if (r_rwfmt == 2'b10) begin
                            w_cnt_nxt = {din, 8'h00};
                        end else begin
                            w_cnt_nxt = {din, r_lsb};
                            w_wst_nxt = W_LSB;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_wst  <= W_IDLE;
                r_cnt  <= '0;
                r_lsb  <= '0;
                r_load <= 1'b0;
            end else begin
                r_wst  <= w_wst_nxt;
                r_cnt  <= w_cnt_nxt;
                r_lsb  <= w_lsb_nxt;
                r_load <= w_load_nxt;
            end
        end

        assign w_src      = r_latched ? r_latch : cnt_in[16*gi +: 16];
        assign w_rd_msb   = (r_rwfmt == 2'b10) || ((r_rwfmt == 2'b11) && r_rdtog);
        assign w_rd_last  = (r_rwfmt != 2'b11) || r_rdtog;
        assign w_rbyte[gi] = w_rd_msb ? w_src[15:8] : w_src[7:0];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_armed   <= 1'b0;
                r_rwfmt   <= 2'b00;
                r_mode    <= 3'd0;
                r_bcd     <= 1'b0;
                r_cw_wr   <= 1'b0;
                r_latched <= 1'b0;
                r_latch   <= '0;
                r_rdtog   <= 1'b0;
            end else begin
                r_cw_wr <= w_cw_set;
                if (w_cw_set) begin
                    r_armed   <= 1'b1;
                    r_rwfmt   <= w_rw;
                    r_mode    <= w_mode_dec;
                    r_bcd     <= din[0] & BCD_EN;
                    r_latched <= 1'b0;
                    r_rdtog   <= 1'b0;
                end else if (w_cw_latch) begin
                    r_latch   <= cnt_in[16*gi +: 16];
                    r_latched <= 1'b1;
                end else if (w_rd_hit && r_armed) begin
                    if (r_rwfmt == 2'b11) r_rdtog <= ~r_rdtog;
                    if (r_latched && w_rd_last) r_latched <= 1'b0;
                end
            end
        end

        assign cnt_val[16*gi +: 16] = r_cnt;
        assign load[gi]             = r_load;
        assign cw_wr[gi]            = r_cw_wr;
        assign mode[3*gi +: 3]      = r_mode;
        assign bcd[gi]              = r_bcd;
        assign armed[gi]            = r_armed;
    end

    // Unarmed channels, the control address and absent channels all read back as zero.
    always_comb begin
        w_rd_data = 8'h00;
        for (int i = 0; i < NCH; i++) begin
            if ((addr == 2'(i)) && armed[i]) w_rd_data = w_rbyte[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout     <= 8'h00;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout_vld <= w_rd_ok;
            if (w_rd_ok) r_dout <= w_rd_data;
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;

endmodule

// File: tb/tb_rw_ctrl.sv
// Scoreboard bench for rw_ctrl: directed bus cycles push expected responses that a
// negedge monitor pops whenever dout_vld, load or cw_wr pulses.
module tb_rw_ctrl;
    localparam int NCH = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr, rd;
    logic [1:0]        addr;
    logic [7:0]        din;
    logic [16*NCH-1:0] cnt_in;
    logic [7:0]        dout;
    logic              dout_vld;
    logic [16*NCH-1:0] cnt_val;
    logic [NCH-1:0]    load, cw_wr, bcd, armed;
    logic [3*NCH-1:0]  mode;

    int errors = 0;
    int checks = 0;

    logic [7:0]  q_rd [$];
    logic [15:0] q_load [NCH][$];
    logic [3:0]  q_cw [NCH][$];

    rw_ctrl #(.NCH(NCH), .BCD_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .addr(addr), .din(din),
        .cnt_in(cnt_in), .dout(dout), .dout_vld(dout_vld), .cnt_val(cnt_val),
        .load(load), .cw_wr(cw_wr), .mode(mode), .bcd(bcd), .armed(armed)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (dout_vld) begin
                if (q_rd.size() == 0) chk("unexpected_dout_vld", {40'd0, dout}, 48'hDEAD);
                else chk("dout", {40'd0, dout}, {40'd0, q_rd.pop_front()});
            end
            for (int c = 0; c < NCH; c++) begin
                if (load[c]) begin
                    if (q_load[c].size() == 0) chk($sformatf("unexpected_load%0d", c), 48'd1, 48'd0);
                    else chk($sformatf("cnt_val%0d", c), {32'd0, cnt_val[16*c +: 16]}, {32'd0, q_load[c].pop_front()});
                end
                if (cw_wr[c]) begin
                    if (q_cw[c].size() == 0) chk($sformatf("unexpected_cw_wr%0d", c), 48'd1, 48'd0);
                    else chk($sformatf("mode_bcd%0d", c), {44'd0, mode[3*c +: 3], bcd[c]}, {44'd0, q_cw[c].pop_front()});
                end
            end
        end
    end

    task automatic do_wr(input logic [1:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; din = d;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic do_rd(input logic [1:0] a, input logic [7:0] exp);
        rd = 1'b1; addr = a;
        q_rd.push_back(exp);
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic do_wrrd(input logic [1:0] a, input logic [7:0] d);
        wr = 1'b1; rd = 1'b1; addr = a; din = d;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"}, {40'd0, dout}, 48'd0);
        chk({tag, "_dout_vld"}, {47'd0, dout_vld}, 48'd0);
        chk({tag, "_cnt_val"}, cnt_val, 48'd0);
        chk({tag, "_load"}, {45'd0, load}, 48'd0);
        chk({tag, "_cw_wr"}, {45'd0, cw_wr}, 48'd0);
        chk({tag, "_mode"}, {39'd0, mode}, 48'd0);
        chk({tag, "_bcd"}, {45'd0, bcd}, 48'd0);
        chk({tag, "_armed"}, {45'd0, armed}, 48'd0);
    endtask

    initial begin
        reset_n = 1'b0; wr = 1'b0; rd = 1'b0; addr = 2'd0; din = 8'h00;
        cnt_in = {16'h5A5A, 16'hABCD, 16'h1234};
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of an LSB/MSB pair.
        q_cw[0].push_back({3'd2, 1'b0});
        do_wr(2'd3, 8'h34);
        do_wr(2'd0, 8'h10);
        reset_n = 1'b0;
        #2;
        chk_all_zero("midpair_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_wr(2'd0, 8'h27);
        @(posedge clk); #1;
        chk("post_reset_armed", {45'd0, armed}, 48'd0);
        chk("post_reset_cnt", cnt_val, 48'd0);

        // ch0 RW=11 mode 2, two-byte load 0x2710.
        q_cw[0].push_back({3'd2, 1'b0});
        do_wr(2'd3, 8'h34);
        do_wr(2'd0, 8'h10);
        q_load[0].push_back(16'h2710);
        do_wr(2'd0, 8'h27);
        @(posedge clk); #1;
        chk("ch0_mode", {45'd0, mode[2:0]}, 48'd2);
        chk("ch0_cnt", {32'd0, cnt_val[15:0]}, 48'h2710);
        chk("ch0_armed", {47'd0, armed[0]}, 48'd1);

        // ch1 RW=01, M=7 aliases to mode 3.
        q_cw[1].push_back({3'd3, 1'b0});
        do_wr(2'd3, 8'h5E);
        q_load[1].push_back(16'h0099);
        do_wr(2'd1, 8'h99);
        do_rd(2'd1, 8'hCD);
        chk("ch1_mode", {45'd0, mode[5:3]}, 48'd3);

        // ch1 RW=10 BCD mode 0: MSB-only load and read.
        q_cw[1].push_back({3'd0, 1'b1});
        do_wr(2'd3, 8'h61);
        q_load[1].push_back(16'h4500);
        do_wr(2'd1, 8'h45);
        do_rd(2'd1, 8'hAB);
        chk("ch1_bcd", {47'd0, bcd[1]}, 48'd1);
        chk("ch0_cnt_held", {32'd0, cnt_val[15:0]}, 48'h2710);

        // Count latch on ch0 with a repeated latch command between reads.
        cnt_in[15:0] = 16'h1234;
        do_wr(2'd3, 8'h00);
        cnt_in[15:0] = 16'h0FFF;
        do_rd(2'd0, 8'h34);
        do_wr(2'd3, 8'h00);
        do_rd(2'd0, 8'h12);
        do_rd(2'd0, 8'hFF);

        // Ignored SC=3 control word and writes to unarmed ch2.
        do_wr(2'd3, 8'hF0);
        do_wr(2'd2, 8'h55);
        do_rd(2'd2, 8'h00);
        do_rd(2'd3, 8'h00);
        chk("ch2_armed", {47'd0, armed[2]}, 48'd0);
        chk("ch2_cnt", {32'd0, cnt_val[47:32]}, 48'd0);
        chk("ch0_mode_kept", {45'd0, mode[2:0]}, 48'd2);

        // wr and rd together on ch0: rd dropped, rd-toggle stays on MSB.
        do_wrrd(2'd0, 8'h88);
        q_load[0].push_back(16'h1388);
        do_wr(2'd0, 8'h13);
        do_rd(2'd0, 8'h0F);

        // Control word mid-pair discards the half-written byte and resets the read toggle.
        q_cw[0].push_back({3'd2, 1'b0});
        do_wr(2'd3, 8'h34);
        do_wr(2'd0, 8'h11);
        q_cw[0].push_back({3'd2, 1'b0});
        do_wr(2'd3, 8'h34);
        do_wr(2'd0, 8'h22);
        q_load[0].push_back(16'h3322);
        do_wr(2'd0, 8'h33);
        do_rd(2'd0, 8'hFF);

        repeat (3) @(posedge clk);
        #1;
        chk("q_rd_drained", q_rd.size(), 48'd0);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("q_load%0d_drained", c), q_load[c].size(), 48'd0);
            chk($sformatf("q_cw%0d_drained", c), q_cw[c].size(), 48'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
